// File: rtl/dro_array_ticked.sv
// Tick-clocked bank of RSFQ destructive-readout cells: stores one pulse per channel, releases it on a shared clock pulse.
// Hold/setup windows are measured in ticks; violating channels read out VIOL_MODE and are counted.
module dro_array_ticked #(
  parameter int WIDTH     = 4,
  parameter int T_HOLD    = 2,
  parameter int T_SETUP   = 3,
  parameter int DELAY     = 4,
  parameter int PULSE_W   = 2,
  parameter int VIOL_MODE = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_pulse,
  input  logic             clk_pulse,
  output logic [WIDTH-1:0] out_pulse,
  output logic [WIDTH-1:0] viol,
  output logic [CNT_W-1:0] viol_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_SET   = 2'd1;
  localparam logic [1:0] ST_UNK   = 2'd2;

  localparam int HC_W  = $clog2(T_HOLD + 2);
  localparam int AGE_W = $clog2(T_SETUP + 2);
  localparam int DEPTH = DELAY + PULSE_W - 1;
  localparam int SR_N  = (DEPTH > 1) ? DEPTH - 1 : 1;
  localparam int SUM_W = $clog2(WIDTH + 1);
  localparam int ACC_W = CNT_W + SUM_W;

  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(T_HOLD);
  localparam logic [HC_W-1:0]  HOLD_CLK = HC_W'((T_HOLD > 0) ? 1 : 0);
  localparam logic             HOLD_ON  = (T_HOLD > 0);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(T_SETUP);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic             UNK_VAL  = (VIOL_MODE != 0);

  logic [WIDTH-1:0][1:0]       state_q, state_d;
  logic [WIDTH-1:0][AGE_W-1:0] age_q, age_d;
  logic [HC_W-1:0]             hold_cnt_q, hold_cnt_d;
  logic [SR_N-1:0][WIDTH-1:0]  sr_q, sr_d;
  logic [WIDTH-1:0]            out_q, out_d;
  logic [WIDTH-1:0]            viol_q, viol_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [WIDTH-1:0]            rd_val;
  logic [WIDTH-1:0]            hold_v;
  logic [WIDTH-1:0]            setup_v;
  logic                        hold_short;
  logic [1:0]                  base_st;
  logic [DEPTH-1:0][WIDTH-1:0] line;
  logic [SUM_W-1:0]            viol_sum;
  logic [ACC_W-1:0]            acc;

  // Cell state, age and hold-window tracking.
  always_comb begin
    state_d    = state_q;
    age_d      = age_q;
    rd_val     = '0;
    hold_v     = '0;
    setup_v    = '0;
    base_st    = ST_EMPTY;
    // A d pulse in the same tick as the clock sits at distance zero from it.
    hold_short = clk_pulse ? HOLD_ON : (hold_cnt_q < HOLD_MAX);
    if (clk_pulse) begin
      hold_cnt_d = HOLD_CLK;
    end else if (hold_cnt_q == HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q;
    end else begin
      hold_cnt_d = hold_cnt_q + HC_W'(1);
    end

    for (int i = 0; i < WIDTH; i++) begin
      setup_v[i] = clk_pulse && (state_q[i] == ST_SET) && (age_q[i] < AGE_MAX);
      if (clk_pulse) begin
        if (state_q[i] == ST_SET && !setup_v[i]) begin
          rd_val[i] = 1'b1;
        end else if (state_q[i] == ST_UNK || setup_v[i]) begin
          rd_val[i] = UNK_VAL;
        end
      end

      base_st = clk_pulse ? ST_EMPTY : state_q[i];
      if (d_pulse[i]) begin
        hold_v[i] = hold_short;
        age_d[i]  = AGE_W'(1);
        if (hold_short) begin
          state_d[i] = ST_UNK;
        end else if (base_st == ST_EMPTY) begin
          state_d[i] = ST_SET;
        end else begin
          state_d[i] = base_st;
        end
      end else begin
        state_d[i] = base_st;
        age_d[i]   = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + AGE_W'(1);
      end
    end
  end

  // Violation flags and saturating counter.
  always_comb begin
    viol_d   = hold_v | setup_v;
    viol_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      viol_sum = viol_sum + SUM_W'(viol_d[i]);
    end
    acc   = ACC_W'(cnt_q) + ACC_W'(viol_sum);
    cnt_d = (acc > ACC_W'(CNT_MAX)) ? CNT_MAX : acc[CNT_W-1:0];
  end

  // line[k] is the readout vector from k ticks ago; out_q adds the final tick of delay.
  always_comb begin
    line[0] = rd_val;
    for (int k = 1; k < DEPTH; k++) begin
      line[k] = sr_q[k-1];
    end
    sr_d = sr_q;
    for (int k = 0; k < SR_N; k++) begin
      sr_d[k] = line[k];
    end
    out_d = '0;
    for (int k = DELAY - 1; k < DEPTH; k++) begin
      out_d = out_d | line[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_EMPTY;
        age_q[i]   <= AGE_MAX;
      end
      hold_cnt_q <= HOLD_MAX;
      sr_q       <= '0;
      out_q      <= '0;
      viol_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      age_q      <= age_d;
      hold_cnt_q <= hold_cnt_d;
      sr_q       <= sr_d;
      out_q      <= out_d;
      viol_q     <= viol_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_pulse  = out_q;
  assign viol       = viol_q;
  assign viol_count = cnt_q;

endmodule

// File: doc/dro_array_ticked.md
# dro_array_ticked

Parameterised, multi-channel, cycle-based model of an RSFQ destructive-readout (DRO) cell bank for the RSFQ library's functional models. Each channel stores one data pulse and releases it on a shared RSFQ clock pulse. All timing runs on a fine-grained simulation tick clock rather than `#` delays. Hold and setup windows are checked in ticks. Violations are resolved deterministically by a mode parameter and are counted, so the bank is synthesizable and usable in cycle-accurate benches.

## Interface
- WIDTH, 4: number of DRO channels (≥1)
- T_HOLD, 2: hold window in ticks after a clock pulse (≥0)
- T_SETUP, 3: setup window in ticks before a clock pulse (≥1)
- DELAY, 4: ticks from clock pulse to first output tick (≥1)
- PULSE_W, 2: output pulse width in ticks (≥1)
- VIOL_MODE, 0: value read out from an UNKNOWN channel (0 or 1)
- CNT_W, 8: width of the violation counter
- clk  in  1  tick clock; single clock domain
- rst  in  1  synchronous, active-high reset
- d_pulse  in  WIDTH  per-channel data pulse; each high tick is one pulse
- clk_pulse  in  1  shared RSFQ clock pulse; each high tick is one pulse
- out_pulse  out  WIDTH  per-channel output pulse
- viol  out  WIDTH  one-tick per-channel violation flag
- viol_count  out  CNT_W  saturating total of violations

## Operation
- Each channel has state EMPTY, SET or UNKNOWN. It also has an age counter of ticks since the channel's last d pulse, saturating at T_SETUP.
- There is one shared counter of ticks since the last clk_pulse, saturating at T_HOLD.
- d pulse on channel i at tick td, with the last clock pulse at tc:
  - If td−tc ≥ T_HOLD: EMPTY→SET, SET stays SET, UNKNOWN stays UNKNOWN.
  - Otherwise (hold violation): state→UNKNOWN.
  - In both cases the age counter restarts at 0.
- clk_pulse at tick tc: every channel is read out in the same tick.
  - A channel is in setup violation if it is SET and its age is < T_SETUP. Its state is treated as UNKNOWN for this readout.
  - Readout value: SET→1, EMPTY→0, UNKNOWN→VIOL_MODE.
  - All channels then return to EMPTY and the clock counter restarts at 0.
- d_pulse and clk_pulse high in the same tick:
  - The clock reads the pre-tick state.
  - The d pulse applies to the new cycle, with td−tc = 0. This is a hold violation iff T_HOLD > 0.
- The readout vector enters a delay line DELAY+PULSE_W−1 deep. out_pulse[i] is the OR of the taps that give the window below. Overlapping windows from back-to-back clocks merge; they do not extend or retrigger beyond each window.
- Violation handling:
  - viol[i] is high for exactly one tick per hold or setup violation event.
  - viol_count adds the number of channels violating in that tick and saturates at 2^CNT_W−1.
- Reset state:
  - All channels EMPTY, age counters saturated, clock counter saturated. A d pulse right after reset is therefore clean.
  - Delay line cleared; out_pulse=0, viol=0, viol_count=0.
- Reset mid-operation discards all pending output pulses and stored states.

## Timing
- All outputs are registered.
- clk_pulse high in tick t ⇒ out_pulse[i] is high in ticks t+DELAY … t+DELAY+PULSE_W−1 if the readout value is 1.
- A hold violation on a d pulse in tick t ⇒ viol[i] high in tick t+1.
- A setup violation on clk_pulse in tick t ⇒ viol[i] high in tick t+1. viol_count updates in the same tick.
- rst high in tick t ⇒ all outputs are 0 in tick t+1. Inputs during rst are ignored.
- Throughput: one clock pulse per tick is accepted. Every clk_pulse clears the bank.

## Test plan
- **Clean store and read:** defaults; d_pulse[0] at 10, clk_pulse at 20 → out_pulse[0] high at 24–25, other channels 0, viol_count=0.
- **Setup violation:** d_pulse[1] at 18, clk_pulse at 20, VIOL_MODE=0 → no output, viol[1] at 21, viol_count=1. With VIOL_MODE=1 → out_pulse[1] high at 24–25.
- **Hold violation:**
  - clk_pulse at 20, d_pulse[2] at 21 → viol[2] at 22.
  - Next clk_pulse at 30 → out_pulse[2] equals VIOL_MODE at 34–35.
  - With d_pulse[2] at 22 instead → no viol, out_pulse[2] high at 34–35.
- **Simultaneous events:**
  - d_pulse[0] at 10 and again at 20, clk_pulse at 20 → out_pulse[0] at 24–25 from the old SET.
  - viol[0] at 21 (hold).
  - Clock at 30 → output VIOL_MODE at 34–35.
- **Back-to-back clocks:** d_pulse[3] at 5, clk_pulse at 20 and 21 → out_pulse[3] high only at 24–25; second readout EMPTY.
- **Reset mid-flight and saturation:**
  - d_pulse[0] at 10, clk_pulse at 20, rst at 22 → out_pulse stays 0 and viol_count=0.
  - With CNT_W=2, 5 violations → viol_count holds at 3.
